gate_arbiter: RTL
=================

GATE_ARBITER -- requirements
Module: gate_arbiter

Interface
REQ-001 Parameter: CNT_W, default 8, width of the completed-transaction counter.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 req  in  2  request from requester i (bit i); held high until gnt[i] is seen.
REQ-006 op0, op1  in  3 each  function select for requester 0 / 1.
REQ-007 a0, b0, a1, b1  in  1 each  operands for requester 0 / 1.
REQ-008 gnt  out  2  one-cycle accept pulse to requester i; operands captured.
REQ-009 rsp_valid  out  1  result available; held until rsp_ready.
REQ-010 rsp_ready  in  1  consumer accepts result.
REQ-011 rsp_id  out  1  index of requester owning the result.
REQ-012 rsp_y  out  1  logic result.
REQ-013 rsp_err  out  1  illegal op flag.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 txn_count  out  CNT_W  number of completed responses.

Function
REQ-016 Op encoding SHALL be 0 NOT a, 1 AND, 2 OR, 3 NAND, 4 NOR, 5 XOR, 6 XNOR; 7 illegal.
REQ-017 FSM states SHALL be IDLE, EXEC and RESP.
REQ-018 IDLE with req!=0 SHALL select a winner, latch its op/a/b, assert gnt[winner] for the next cycle, and move to EXEC.
REQ-019 IDLE with req==0 SHALL stay in IDLE with all outputs unchanged.
REQ-020 EXEC SHALL register the result into rsp_y/rsp_err/rsp_id and move to RESP; gnt SHALL be high only during EXEC.
REQ-021 RESP SHALL hold rsp_valid=1 and stable rsp_* until rsp_ready=1.
REQ-022 On acceptance (rsp_valid and rsp_ready), RESP SHALL drop rsp_valid, increment txn_count, and return to IDLE.
REQ-023 Latency: req sampled at edge k -> gnt high in cycle k+1 -> rsp_valid high from cycle k+2.
REQ-024 Minimum spacing between grants SHALL be 3 cycles.
REQ-025 Arbitration SHALL be round-robin: with both requesting, the requester not granted last SHALL win.
REQ-026 A single requester SHALL win regardless of the pointer.
REQ-027 The last-grant pointer SHALL update only on a grant.
REQ-028 req, op and operand changes outside IDLE SHALL be ignored.
REQ-029 A req still high in the cycle gnt is asserted SHALL NOT cause a second grant.
REQ-030 Op 7 SHALL give rsp_y=0 and rsp_err=1; the transaction completes normally and is counted.
REQ-031 txn_count SHALL wrap from 2^CNT_W-1 to 0 without flagging.
REQ-032 rsp_ready while rsp_valid=0 SHALL have no effect.

Reset
REQ-033 While rst=1 at an edge, state SHALL go to IDLE, and gnt, rsp_valid, rsp_id, rsp_y, rsp_err and busy SHALL be 0.
REQ-034 txn_count SHALL be 0 after reset, and the last-grant pointer SHALL be 1, so requester 0 wins first.
REQ-035 Reset mid-transaction (EXEC or RESP) SHALL abandon the transaction with no response and no count increment.
REQ-036 rst SHALL override all other inputs in the same cycle.

Structure
REQ-037 Shared package gate_arb_pkg SHALL hold the op encodings (OP_NOT..OP_XNOR, OP_ILL=7) and the FSM state type.
REQ-038 Sub-module gate_unit SHALL be combinational: inputs op, a, b; outputs y, err; one instance on the latched operands.
REQ-039 All outputs SHALL be driven from registers.

Verification
REQ-040 Reset, then req=01, op0=1, a0=1, b0=1: gnt=01 one cycle later, then rsp_valid=1, rsp_id=0, rsp_y=1, rsp_err=0, and txn_count=1 after rsp_ready.
REQ-041 req=11 held, rsp_ready=1, op0=5 (a0=1, b0=0), op1=4 (a1=0, b1=0): grants in the order 0,1,0,1; each rsp_y=1; each requester drops req after its gnt.
REQ-042 Sweep ops 0..6 on requester 1 with {a1,b1} over 00..11: rsp_y SHALL match the truth table (e.g., a=1, b=0 gives NOT=0, AND=0, OR=1, NAND=1, NOR=0, XOR=1, XNOR=0).
REQ-043 op0=7: rsp_err=1, rsp_y=0, and txn_count increments.
REQ-044 rsp_ready held 0 for 5 cycles in RESP: rsp_* stable and busy=1 throughout; no new gnt despite req=10.
REQ-045 Assert rst in the EXEC cycle: next cycle rsp_valid=0 and txn_count unchanged; with CNT_W=8, 256 transactions return txn_count to 0.

Source files
------------

// File: rtl/gate_arb_pkg.sv
// Shared definitions for the two-requester gate arbiter: operation encodings
// and the controller state type.
package gate_arb_pkg;

  typedef enum logic [2:0] {
    OP_NOT  = 3'd0,
    OP_AND  = 3'd1,
    OP_OR   = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_ILL  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/gate_unit.sv
// Combinational single-bit logic unit; the one reserved encoding yields y=0
// with err raised.
module gate_unit
  import gate_arb_pkg::*;
(
  input  op_e  op,
  input  logic a,
  input  logic b,
  output logic y,
  output logic err
);

  // NOTE: defaults first so no path through the case leaves y/err unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    y   = 1'b0;
    err = 1'b0;
    case (op)
      OP_NOT:  y = ~a;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/gate_arbiter.sv
// Round-robin arbiter in front of one shared gate_unit: grant, evaluate the
// latched operands, then hold the response until the consumer takes it.
module gate_arbiter
  import gate_arb_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [2:0]       op0,
  input  logic [2:0]       op1,
  input  logic             a0,
  input  logic             b0,
  input  logic             a1,
  input  logic             b1,
  output logic [1:0]       gnt,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic             rsp_y,
  output logic             rsp_err,
  output logic             busy,
  output logic [CNT_W-1:0] txn_count
);

  state_e           state_q, state_d;
  logic             last_q, last_d;
  op_e              op_q, op_d;
  logic             a_q, a_d, b_q, b_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic             rsp_y_q, rsp_y_d;
  logic             rsp_err_q, rsp_err_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic win;
  logic unit_y, unit_err;

  // On contention the requester that was not granted last wins.
  assign win = (req == 2'b11) ? ~last_q : req[1];

  gate_unit u_gate_unit (
    .op  (op_q),
    .a   (a_q),
    .b   (b_q),
    .y   (unit_y),
    .err (unit_err)
  );

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    gnt_d       = 2'b00;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_y_d     = rsp_y_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (req != 2'b00) begin
          state_d = ST_EXEC;
          last_d  = win;
          gnt_d   = win ? 2'b10 : 2'b01;
          op_d    = op_e'(win ? op1 : op0);
          a_d     = win ? a1 : a0;
          b_d     = win ? b1 : b0;
        end
      end
      ST_EXEC: begin
        // last_q already names the owner; it was updated with the grant.
        rsp_valid_d = 1'b1;
        rsp_id_d    = last_q;
        rsp_y_d     = unit_y;
        rsp_err_d   = unit_err;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cnt_d       = cnt_q + CNT_W'(1);
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      last_q      <= 1'b1;
      op_q        <= OP_NOT;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      gnt_q       <= 2'b00;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_y_q     <= 1'b0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_y_q     <= rsp_y_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;
  assign txn_count = cnt_q;

endmodule
